hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/hazard_unit_if.sv | 25 ++
 rtl/sb_counter.sv | 23 ++
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, including the hazard scoreboard state enum
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        HALTED
    } hzrd_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: decode/execute to hazard unit signals, hzrd modport is the hazard unit's view
interface hazard_unit_if;
    import cpu_types_pkg::*;

    logic                issue_valid;
    regbits_t [1:0]      issue_rs;
    regbits_t            issue_rd;
    logic                issue_wen;
    logic [2:0]          issue_lat;
    logic                is_branch_taken;
    logic                ihit;
    logic                dhit;
    logic                ex_mem_dmemREN;
    logic                ex_mem_halt;
    logic                stall;
    logic                flush;
    logic [31:0]         busy_mask;
    logic                halted;

    modport hzrd (
        input  issue_valid, issue_rs, issue_rd, issue_wen, issue_lat,
        input  is_branch_taken, ihit, dhit, ex_mem_dmemREN, ex_mem_halt,
        output stall, flush, busy_mask, halted
    );
endinterface

// File: rtl/sb_counter.sv
// sb_counter: one register's result countdown; a new load beats the decrement, memory wait freezes it
module sb_counter #(
    parameter int LW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [LW-1:0] lat_i,
    input  logic          hold_i,
    output logic [LW-1:0] cnt_o
);
    logic [LW-1:0] cnt_q, cnt_d;

    // next count: load first, then hold, then saturating decrement
    always_comb cnt_d = load_i ? lat_i : (hold_i || cnt_q == '0) ? cnt_q : cnt_q - LW'(1);

    // countdown register, cleared immediately by reset
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register result scoreboard with RAW/WAW stall, branch flush window and halt state
module hazard_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int NSRC      = 2,
    parameter int MAXLAT    = 4,
    parameter int FLUSH_CYC = 2,
    localparam int LW       = $clog2(MAXLAT + 1),
    localparam int RB       = $clog2(NREG)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     issue_valid,
    input  logic [NSRC-1:0][RB-1:0]  issue_rs,
    input  logic [RB-1:0]            issue_rd,
    input  logic                     issue_wen,
    input  logic [LW-1:0]            issue_lat,
    input  logic                     is_branch_taken,
    input  logic                     ihit,
    input  logic                     dhit,
    input  logic                     ex_mem_dmemREN,
    input  logic                     ex_mem_halt,
    output logic                     stall,
    output logic                     flush,
    output logic [NREG-1:0]          busy_mask,
    output logic                     halted
);
    localparam int FW = FLUSH_CYC > 1 ? $clog2(FLUSH_CYC) : 1;

    hzrd_state_t   state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [LW-1:0] cnt [NREG];
    logic          mem_wait, raw, waw, accept;

    assign mem_wait = ex_mem_dmemREN && !dhit;
    assign accept   = issue_valid && !stall && !flush;
    assign cnt[0]   = '0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_sb
            sb_counter #(.LW(LW)) u_cnt (
                .clk_i  (CLK),
                .rst_i  (RST),
                .load_i (accept && issue_wen && issue_rd == RB'(r) && issue_lat != '0),
                .lat_i  (issue_lat),
                .hold_i (mem_wait),
                .cnt_o  (cnt[r])
            );
        end
        for (r = 0; r < NREG; r++) begin : g_busy
            assign busy_mask[r] = cnt[r] != '0;
        end
    endgenerate

    // hazard detection against the current scoreboard
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < NSRC; i++)
            raw = raw | (issue_rs[i] != '0 && cnt[issue_rs[i]] != '0);
        waw = issue_wen && issue_rd != '0 && cnt[issue_rd] > issue_lat;
    end

    // state and flush counter registers
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end

    // next state: halt wins everywhere, a branch (re)opens the flush window
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (ex_mem_halt) state_d = HALTED;
        else
            case (state_q)
                IDLE:
                    if (is_branch_taken) begin
                        state_d = FLUSH;
                        fcnt_d  = FW'(FLUSH_CYC - 1);
                    end
                FLUSH:
                    if (is_branch_taken) fcnt_d = FW'(FLUSH_CYC - 1);
                    else if (fcnt_q == '0) state_d = IDLE;
                    else fcnt_d = fcnt_q - FW'(1);
                default: state_d = HALTED;
            endcase
    end

    // outputs decoded from state plus the combinational stall condition
    always_comb begin
        flush  = state_q == FLUSH;
        halted = state_q == HALTED;
        stall  = (issue_valid && (raw || waw)) || !ihit || mem_wait || halted;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: randomized and directed stimulus against a behavioural scoreboard model
module tb_hazard_scoreboard;
    localparam int NREG = 32;
    localparam int FC   = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            issue_valid = 1'b0;
    logic [1:0][4:0] issue_rs = '0;
    logic [4:0]      issue_rd = '0;
    logic            issue_wen = 1'b0;
    logic [2:0]      issue_lat = '0;
    logic            is_branch_taken = 1'b0;
    logic            ihit = 1'b1;
    logic            dhit = 1'b1;
    logic            ex_mem_dmemREN = 1'b0;
    logic            ex_mem_halt = 1'b0;
    logic            stall, flush, halted;
    logic [31:0]     busy_mask;

    int n_chk = 0;
    int n_pass = 0;

    int cnt_m [NREG];
    int flush_left;
    bit halted_m;

    hazard_scoreboard #(.NREG(NREG), .NSRC(2), .MAXLAT(4), .FLUSH_CYC(FC)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .issue_valid     (issue_valid),
        .issue_rs        (issue_rs),
        .issue_rd        (issue_rd),
        .issue_wen       (issue_wen),
        .issue_lat       (issue_lat),
        .is_branch_taken (is_branch_taken),
        .ihit            (ihit),
        .dhit            (dhit),
        .ex_mem_dmemREN  (ex_mem_dmemREN),
        .ex_mem_halt     (ex_mem_halt),
        .stall           (stall),
        .flush           (flush),
        .busy_mask       (busy_mask),
        .halted          (halted)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
        flush_left = 0;
        halted_m   = 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        issue_valid = 1'b0; ihit = 1'b1; ex_mem_dmemREN = 1'b0;
        is_branch_taken = 1'b0; ex_mem_halt = 1'b0;
        RST = 1'b1;
        #1;
        model_reset();
        check("rst_flush", {31'b0, flush}, 0);
        check("rst_halted", {31'b0, halted}, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_stall", {31'b0, stall}, 0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic step(input bit v, input int a, input int b, input int d, input bit w,
                        input int l, input bit br, input bit ih, input bit dh,
                        input bit ren, input bit hlt);
        bit raw, waw, mw, st, fl, acc;
        logic [31:0] bm;
        @(negedge CLK);
        issue_valid = v; issue_rs[0] = 5'(a); issue_rs[1] = 5'(b); issue_rd = 5'(d);
        issue_wen = w; issue_lat = 3'(l); is_branch_taken = br; ihit = ih; dhit = dh;
        ex_mem_dmemREN = ren; ex_mem_halt = hlt;
        #1;
        raw = (a != 0 && cnt_m[a] > 0) || (b != 0 && cnt_m[b] > 0);
        waw = w && d != 0 && cnt_m[d] > l;
        mw  = ren && !dh;
        st  = (v && (raw || waw)) || !ih || mw || halted_m;
        fl  = !halted_m && flush_left > 0;
        bm  = '0;
        for (int r = 0; r < NREG; r++) bm[r] = cnt_m[r] > 0;
        check("stall", {31'b0, stall}, {31'b0, st});
        check("flush", {31'b0, flush}, {31'b0, fl});
        check("halted", {31'b0, halted}, {31'b0, halted_m});
        check("busy", busy_mask, bm);
        acc = v && !st && !fl;
        for (int r = 0; r < NREG; r++) if (!mw && cnt_m[r] > 0) cnt_m[r]--;
        if (acc && w && d != 0 && l != 0) cnt_m[d] = l;
        if (hlt) begin
            halted_m = 1'b1;
            flush_left = 0;
        end else if (!halted_m) begin
            if (br) flush_left = FC;
            else if (flush_left > 0) flush_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    endtask

    initial begin
        model_reset();
        do_reset();
        // load-use: lw x5 lat 2 then add x6,x5,x1 held until x5 is free
        step(1, 0, 0, 5, 1, 2, 0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 5, 1, 6, 1, 1, 0, 1, 1, 0, 0);
        idle(3);
        // memory wait freezes the scoreboard
        step(1, 0, 0, 5, 1, 2, 0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        idle(3);
        // branch window, then back-to-back branches
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        step(1, 0, 0, 9, 1, 3, 1, 1, 1, 0, 0);
        idle(4);
        // x0 is never busy; WAW on x7
        step(1, 0, 0, 0, 1, 3, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 7, 1, 4, 0, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 7, 1, 1, 0, 1, 1, 0, 0);
        idle(3);
        // branch and halt together: halt wins and sticks
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 4, 1, 2, 1, 1, 1, 0, 0);
        do_reset();
        // reset mid-flush with x3 pending, then read x3
        step(1, 0, 0, 3, 1, 3, 1, 1, 1, 0, 0);
        do_reset();
        step(1, 3, 3, 2, 1, 1, 0, 1, 1, 0, 0);
        idle(2);
        // random traffic in segments, reset between them
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 400; k++)
                step($urandom_range(9, 0) < 7, $urandom_range(7, 0), $urandom_range(7, 0),
                     $urandom_range(7, 0), $urandom_range(3, 0) != 0, $urandom_range(4, 0),
                     $urandom_range(11, 0) == 0, $urandom_range(9, 0) != 0,
                     $urandom_range(4, 0) < 3, $urandom_range(4, 0) == 0,
                     $urandom_range(499, 0) == 0);
            do_reset();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
